// File: rtl/seq_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seq_decoder
// Function : Registered, handshaked binary-to-one-hot decoder with optional
//            sweep mode (compiled in when SEQ_DECODER_SWEEP_EN is defined).
// Revision : 1.0
// ============================================================================
module seq_decoder #(
    parameter int ENCODE_WIDTH = 4,
    parameter int DECODE_WIDTH = 1 << ENCODE_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ENCODE_WIDTH-1:0] in_index,
    input  logic                    in_sweep,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DECODE_WIDTH-1:0] out_onehot,
    output logic                    out_last,
    output logic                    out_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_SWEEP = 2'd2
    } state_t;

    state_t                  r_state;
    logic                    w_busy;
    logic                    w_accept;
    logic                    w_out_hs;
    logic                    w_in_range;
    logic [DECODE_WIDTH-1:0] w_onehot;

    // Widened compare so a full-width DECODE_WIDTH is not a constant-false test.
    assign w_in_range = ({1'b0, in_index} < (ENCODE_WIDTH + 1)'(DECODE_WIDTH));
    assign w_onehot   = DECODE_WIDTH'(1) << in_index;
    assign w_accept   = in_valid && in_ready;
    assign w_out_hs   = out_valid && out_ready;
    assign in_ready   = !rst && !w_busy && (!out_valid || out_ready);

`ifdef SEQ_DECODER_SWEEP_EN
    logic [ENCODE_WIDTH-1:0] r_count;
    logic [ENCODE_WIDTH-1:0] r_target;
    logic [ENCODE_WIDTH-1:0] w_count_next;

    assign w_busy       = (r_state == ST_SWEEP);
    assign w_count_next = r_count + ENCODE_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            out_valid  <= 1'b0;
            out_onehot <= '0;
            out_last   <= 1'b0;
            out_err    <= 1'b0;
            r_count    <= '0;
            r_target   <= '0;
        end else if (w_accept) begin
            out_valid <= 1'b1;
            r_count   <= '0;
            if (!w_in_range) begin
                r_state    <= ST_HOLD;
                out_onehot <= '0;
                out_last   <= 1'b1;
                out_err    <= 1'b1;
            end else if (in_sweep && (in_index != '0)) begin
                r_state    <= ST_SWEEP;
                r_target   <= in_index;
                out_onehot <= DECODE_WIDTH'(1);
                out_last   <= 1'b0;
                out_err    <= 1'b0;
            end else begin
                r_state    <= ST_HOLD;
                out_onehot <= w_onehot;
                out_last   <= 1'b1;
                out_err    <= 1'b0;
            end
        end else if (w_out_hs && (r_state == ST_SWEEP)) begin
            // Next beat is the neighbouring bit; counter stops at the target.
            r_count    <= w_count_next;
            out_onehot <= out_onehot << 1;
            if (w_count_next == r_target) begin
                r_state  <= ST_HOLD;
                out_last <= 1'b1;
            end
        end else if (w_out_hs) begin
            r_state    <= ST_IDLE;
            out_valid  <= 1'b0;
            out_onehot <= '0;
            out_last   <= 1'b0;
            out_err    <= 1'b0;
        end
    end
`else
    logic w_unused_sweep;

    assign w_busy         = 1'b0;
    assign w_unused_sweep = in_sweep;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            out_valid  <= 1'b0;
            out_onehot <= '0;
            out_last   <= 1'b0;
            out_err    <= 1'b0;
        end else if (w_accept) begin
            r_state    <= ST_HOLD;
            out_valid  <= 1'b1;
            out_onehot <= w_in_range ? w_onehot : '0;
            out_last   <= 1'b1;
            out_err    <= !w_in_range;
        end else if (w_out_hs) begin
            r_state    <= ST_IDLE;
            out_valid  <= 1'b0;
            out_onehot <= '0;
            out_last   <= 1'b0;
            out_err    <= 1'b0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_decoder
// Function : Scoreboard bench for seq_decoder (16-wide main, 10-wide error DUT).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_seq_decoder;

`ifdef SEQ_DECODER_SWEEP_EN
    localparam bit SWEEP_EN = 1'b1;
`else
    localparam bit SWEEP_EN = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] onehot;
        logic        last;
        logic        err;
    } beat_t;

    beat_t q[$];
    int    checks = 0;
    int    errors = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_sweep, out_valid, out_ready, out_last, out_err;
    logic [3:0]  in_index;
    logic [15:0] out_onehot;

    logic        e_in_valid, e_in_ready, e_in_sweep, e_out_valid, e_out_ready, e_out_last, e_out_err;
    logic [3:0]  e_in_index;
    logic [9:0]  e_out_onehot;

    always #5 clk = ~clk;

    seq_decoder #(.ENCODE_WIDTH(4), .DECODE_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_index(in_index), .in_sweep(in_sweep),
        .out_valid(out_valid), .out_ready(out_ready), .out_onehot(out_onehot),
        .out_last(out_last), .out_err(out_err)
    );

    seq_decoder #(.ENCODE_WIDTH(4), .DECODE_WIDTH(10)) dut_err (
        .clk(clk), .rst(rst),
        .in_valid(e_in_valid), .in_ready(e_in_ready), .in_index(e_in_index), .in_sweep(e_in_sweep),
        .out_valid(e_out_valid), .out_ready(e_out_ready), .out_onehot(e_out_onehot),
        .out_last(e_out_last), .out_err(e_out_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void push_cmd(input logic [3:0] idx, input logic sw);
        if (SWEEP_EN && sw) begin
            for (int k = 0; k <= int'(idx); k++)
                q.push_back(beat_t'{onehot: 16'd1 << k, last: (k == int'(idx)), err: 1'b0});
        end else begin
            q.push_back(beat_t'{onehot: 16'd1 << idx, last: 1'b1, err: 1'b0});
        end
    endfunction

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic tick(input string tag);
        logic  exp_ready;
        logic  hs_in;
        logic  hs_out;
        beat_t b;
        #1;
        exp_ready = !rst && (q.size() <= 1) && ((q.size() == 0) || out_ready);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ready));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            b = q[0];
            chk({tag, ".onehot"}, 32'(out_onehot), 32'(b.onehot));
            chk({tag, ".last"}, 32'(out_last), 32'(b.last));
            chk({tag, ".err"}, 32'(out_err), 32'(b.err));
        end
        hs_out = out_ready && (q.size() > 0);
        hs_in  = in_valid && exp_ready;
        if (rst) begin
            q.delete();
        end else begin
            if (hs_out) void'(q.pop_front());
            if (hs_in) push_cmd(in_index, in_sweep);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_index = 4'd0; in_sweep = 1'b0; out_ready = 1'b1;
        e_in_valid = 1'b0; e_in_index = 4'd0; e_in_sweep = 1'b0; e_out_ready = 1'b1;
        @(negedge clk);

        // Reset held with in_valid high: nothing accepted, outputs quiet.
        for (int c = 0; c < 3; c++) begin
            tick("reset");
            chk("reset.onehot_zero", 32'(out_onehot), 32'h0);
        end
        rst = 1'b0;

        // Back-to-back single-mode indices 0..15.
        for (int i = 0; i < 16; i++) begin
            in_index = 4'(i);
            tick("single");
        end
        in_valid = 1'b0;
        tick("single_drain");
        tick("idle");

        // Out-of-range index on the 10-wide instance, sweep requested.
        e_in_index = 4'd12; e_in_sweep = 1'b1; e_in_valid = 1'b1;
        #1 chk("err.in_ready", 32'(e_in_ready), 32'h1);
        @(negedge clk);
        e_in_valid = 1'b0;
        #1;
        chk("err.out_valid", 32'(e_out_valid), 32'h1);
        chk("err.onehot", 32'(e_out_onehot), 32'h0);
        chk("err.err", 32'(e_out_err), 32'h1);
        chk("err.last", 32'(e_out_last), 32'h1);
        @(negedge clk);
        #1 chk("err.single_beat", 32'(e_out_valid), 32'h0);
        e_in_index = 4'd9; e_in_sweep = 1'b0; e_in_valid = 1'b1;
        @(negedge clk);
        e_in_valid = 1'b0;
        #1;
        chk("err.edge_onehot", 32'(e_out_onehot), 32'h200);
        chk("err.edge_err", 32'(e_out_err), 32'h0);
        @(negedge clk);

        // Back-pressure: index 5 held for 4 cycles, then handshake plus new accept.
        in_index = 4'd5; in_sweep = 1'b0; in_valid = 1'b1;
        tick("bp_accept");
        in_index = 4'd6; out_ready = 1'b0;
        for (int c = 0; c < 4; c++) tick("bp_hold");
        out_ready = 1'b1;
        tick("bp_release");
        in_valid = 1'b0;
        tick("bp_next");
        tick("bp_idle");

        // Sweep of index 3.
        in_index = 4'd3; in_sweep = 1'b1; in_valid = 1'b1;
        tick("sweep_accept");
        in_valid = 1'b0; in_sweep = 1'b0;
        for (int c = 0; c < 5; c++) tick("sweep");

        // Reset in the middle of a sweep of index 7.
        in_index = 4'd7; in_sweep = 1'b1; in_valid = 1'b1;
        tick("mid_accept");
        in_valid = 1'b0; in_sweep = 1'b0;
        tick("mid_beat0");
        tick("mid_beat1");
        rst = 1'b1;
        tick("mid_rst");
        #1;
        chk("mid_rst.onehot", 32'(out_onehot), 32'h0);
        chk("mid_rst.last", 32'(out_last), 32'h0);
        chk("mid_rst.err", 32'(out_err), 32'h0);
        @(negedge clk);
        tick("mid_rst_hold");
        rst = 1'b0;
        in_index = 4'd1; in_valid = 1'b1;
        tick("post_rst_accept");
        in_valid = 1'b0;
        tick("post_rst_beat");
        tick("post_rst_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_decoder.md
# seq_decoder

Registered, handshaked binary-to-one-hot decoder that succeeds the combinational decoder in the simulation library. It accepts a binary index on a valid/ready input channel and returns one-hot words on a valid/ready output channel. Indices at or beyond DECODE_WIDTH are flagged as errors. An optional sweep mode expands one index N into N+1 consecutive one-hot beats (bit 0 through bit N). The block feeds select/strobe fabrics that need back-pressure-safe, registered enables.

## Interface
- ENCODE_WIDTH, 4: index width in bits.
- DECODE_WIDTH, 1 << ENCODE_WIDTH: one-hot output width; legal range 2 to 1 << ENCODE_WIDTH.
- clk  input  1  sole clock; all logic on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  index presented.
- in_ready  output  1  block accepts the index this cycle.
- in_index  input  ENCODE_WIDTH  binary index.
- in_sweep  input  1  mode for this index: 0 = single beat, 1 = sweep.
- out_valid  output  1  output beat presented.
- out_ready  input  1  consumer accepts the beat.
- out_onehot  output  DECODE_WIDTH  one-hot word; all zeros on an error beat.
- out_last  output  1  final beat of the current command.
- out_err  output  1  index was at or above DECODE_WIDTH.

## Operation
- Accept: fires when in_valid && in_ready.
- in_ready = !rst && !busy && (!out_valid || out_ready).
  - busy is high while sweep beats remain after the current one.
- Single mode, in-range index i:
  - one beat with out_onehot = 1 << i, out_last = 1, out_err = 0.
- Sweep mode, in-range index N:
  - beats k = 0..N, one per output handshake.
  - each beat has out_onehot = 1 << k.
  - out_last = 1 only on k = N.
  - busy is set from accept until the beat with k = N is issued.
  - the beat counter is ENCODE_WIDTH bits and never wraps: it stops at N.
- Out-of-range index (in_index >= DECODE_WIDTH), either mode:
  - exactly one beat with out_onehot = 0, out_err = 1, out_last = 1.
  - no sweep is started.
- States:
  - IDLE: out_valid = 0.
  - HOLD: out_valid = 1, beat presented.
  - SWEEP: out_valid = 1 and more beats pending.
  - IDLE -> HOLD or SWEEP on accept.
  - SWEEP -> SWEEP on handshake with k+1 < N.
  - SWEEP -> HOLD on handshake issuing k = N.
  - HOLD -> HOLD on a handshake coinciding with a new accept (back-to-back).
  - HOLD -> IDLE on a handshake with no accept.
- Back-pressure: while out_valid && !out_ready, out_onehot, out_last and out_err hold stable.
- Simultaneous events: an output handshake and an input accept in the same cycle are legal. The new beat replaces the old one with no bubble.
- Reset mid-operation: any pending sweep is discarded.
- Reset values: out_valid = 0, out_onehot = 0, out_last = 0, out_err = 0, beat counter = 0, busy = 0. in_ready = 0 while rst is high.

## Timing
- Latency: first beat is valid on the cycle after accept.
- Single-mode throughput: one index per cycle while out_ready stays high.
- Sweep of N: N+1 output cycles with out_ready held high.
  - in_ready is low for N of those cycles.
  - in_ready is high on the cycle the k = N beat is presented.
- All outputs are registered except in_ready, which is combinational from state, rst and out_ready.
- No combinational path from in_valid or in_index to any output.

## Configuration
- SEQ_DECODER_SWEEP_EN defined:
  - sweep mode, the beat counter and the SWEEP state are compiled in.
  - behaviour is as above.
- SEQ_DECODER_SWEEP_EN undefined:
  - in_sweep is ignored and every index produces exactly one beat with out_last = 1.
  - busy is tied 0 and no counter logic is synthesised.

## Test plan
- Reset: hold rst for 3 cycles with in_valid = 1 -> in_ready = 0, out_valid = 0, out_onehot = 16'h0000 throughout. First accept occurs on the cycle after rst falls.
- Single sweep of all indices: feed i = 0..15 back-to-back with out_ready = 1 -> out_onehot = 1 << i each cycle, one-cycle latency, out_last = 1 on every beat, no bubbles.
- Back-pressure: accept index 5, hold out_ready = 0 for 4 cycles -> out_onehot stays 16'h0020 and in_ready stays 0. Release -> one handshake, then the next index is accepted the same cycle.
- Sweep (macro defined): in_index = 3, in_sweep = 1, out_ready = 1 -> beats 16'h0001, 0002, 0004, 0008; out_last only on 0008; in_ready low during beats 0001 through 0004.
- Error: DECODE_WIDTH = 10, in_index = 12 with in_sweep = 1 -> one beat with out_onehot = 0, out_err = 1, out_last = 1.
- Reset mid-sweep: index 7 in sweep mode, assert rst after beat 2 -> next cycle all outputs are zero. After rst falls, a new index 1 in single mode yields a single 16'h0002 beat.
